// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter used as a delay / period generator. A start value N
//   is taken through a valid/ready handshake; the timer then counts down on
//   enabled cycles and pulses tc for one cycle when the count expires. In
//   periodic mode the count reloads to N on expiry and keeps running.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   en          count enable (low = hold)
//   load_valid  start request; paired with load_value / periodic
//   load_ready  timer can accept a load this cycle (combinational)
//   load_value  start value N, sampled on accept
//   periodic    1 = auto-reload, 0 = one-shot, sampled on accept
//   abort       cancel the run in progress; blocks a load while idle
//   count       remaining count (registered)
//   busy        high while running
//   tc          one-cycle terminal-count pulse (registered)
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_p0, state_n;
  logic [WIDTH-1:0]   count_p0, count_n;
  logic [WIDTH-1:0]   reload_p0, reload_n;
  logic               mode_p0, mode_n;
  logic               tc_p0, tc_n;
  logic               accept;

  // Decrement that saturates at zero so the count can never wrap.
  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    if (v == '0) return '0;
    return v - 1'b1;
  endfunction

  assign load_ready = (state_p0 == IDLE) && !abort;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_n  = state_p0;
    count_n  = count_p0;
    reload_n = reload_p0;
    mode_n   = mode_p0;
    tc_n     = 1'b0;
    case (state_p0)
      IDLE: begin
        if (accept) begin
          if (load_value != '0) begin
            count_n  = load_value;
            reload_n = load_value;
            mode_n   = periodic;
            state_n  = RUN;
          end else begin
            // Zero start value expires immediately without entering RUN.
            count_n = '0;
            tc_n    = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_n = '0;
          state_n = IDLE;
        end else if (en) begin
          if (count_p0 > 1) begin
            count_n = dec_sat(count_p0);
          end else begin
            tc_n = 1'b1;
            if (mode_p0) begin
              count_n = reload_p0;
            end else begin
              count_n = '0;
              state_n = IDLE;
            end
          end
        end
      end
      default: begin
        count_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Register stage: all state, count and the tc pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= IDLE;
      count_p0  <= '0;
      reload_p0 <= '0;
      mode_p0   <= 1'b0;
      tc_p0     <= 1'b0;
    end else begin
      state_p0  <= state_n;
      count_p0  <= count_n;
      reload_p0 <= reload_n;
      mode_p0   <= mode_n;
      tc_p0     <= tc_n;
    end
  end

  assign count = count_p0;
  assign tc    = tc_p0;
  assign busy  = (state_p0 == RUN);

endmodule
